// File: rtl/issue_decode.sv
// issue_decode: FIFO-buffered instruction issue for regalu, holding the
// head back with bubbles until an in-flight write to its sources lands.
module issue_decode #(
   parameter int DEPTH     = 4,
   parameter int HAZ_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            in_instr,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [4:0]             RR1,
   output logic [4:0]             RR2,
   output logic [4:0]             WR,
   output logic [2:0]             INop,
   output logic                   issue_valid,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [15:0]            stall_cycles
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HN = (HAZ_DEPTH > 1) ? HAZ_DEPTH - 1 : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [2:0] op;
      logic [4:0] wr, rr1, rr2;
   } uop_t;

   uop_t          mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   uop_t          iss_q, iss_d;
   logic          vld_q, vld_d;
   logic [4:0]    hist_q [HN];
   logic [4:0]    hist_d [HN];
   logic [15:0]   stall_q, stall_d;

   uop_t head, in_uop;
   logic push, pop, empty, hazard;
   logic unused_bits;

   function automatic logic blocks(input logic [4:0] src,
                                   input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

   assign in_uop = '{op:  in_instr[31:29], wr:  in_instr[28:24],
                     rr1: in_instr[23:19], rr2: in_instr[18:14]};
   assign unused_bits = ^in_instr[13:0];

   always_comb begin
      in_ready = rst_n && (count_q < FULL);
      push     = in_valid && in_ready;
      empty    = (count_q == '0);
      head     = mem_q[rd_ptr_q];

      // Bubbles carry WR=0, so they never match a nonzero source.
      hazard = blocks(head.rr1, iss_q.wr) || blocks(head.rr2, iss_q.wr);
      for (int i = 0; i < HAZ_DEPTH - 1; i++) begin
         hazard = hazard || blocks(head.rr1, hist_q[i])
                         || blocks(head.rr2, hist_q[i]);
      end

      pop   = !empty && !hazard;
      iss_d = pop ? head : '0;
      vld_d = pop;

      hist_d[0] = iss_q.wr;
      for (int i = 1; i < HN; i++) begin
         hist_d[i] = hist_q[i-1];
      end

      stall_d = stall_q;
      if (!empty && hazard && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end

      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_uop;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         iss_q    <= '0;
         vld_q    <= 1'b0;
         stall_q  <= '0;
         for (int i = 0; i < HN; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         iss_q    <= iss_d;
         vld_q    <= vld_d;
         stall_q  <= stall_d;
         for (int i = 0; i < HN; i++) begin
            hist_q[i] <= hist_d[i];
         end
      end
   end

   assign RR1          = iss_q.rr1;
   assign RR2          = iss_q.rr2;
   assign WR           = iss_q.wr;
   assign INop         = iss_q.op;
   assign issue_valid  = vld_q;
   assign fifo_count   = count_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_decode.sv
// Scoreboard bench for issue_decode: timing-based reference model plus a
// second instance with a deep hazard window to reach counter saturation.
module tb_issue_decode;

   localparam int DEPTH = 4;
   localparam int HAZ   = 2;
   localparam int SHAZ  = 64;
   localparam int SAT_N = 1030;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, in_ready, issue_valid;
   logic [31:0] in_instr;
   logic [4:0]  RR1, RR2, WR;
   logic [2:0]  INop;
   logic [2:0]  fifo_count;
   logic [15:0] stall_cycles;

   logic        s_rst_n, s_in_valid, s_in_ready, s_issue_valid;
   logic [31:0] s_in_instr;
   logic [4:0]  s_RR1, s_RR2, s_WR;
   logic [2:0]  s_INop;
   logic [2:0]  s_fifo_count;
   logic [15:0] s_stall;

   issue_decode #(.DEPTH(DEPTH), .HAZ_DEPTH(HAZ)) dut (
      .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid),
      .in_ready(in_ready), .RR1(RR1), .RR2(RR2), .WR(WR), .INop(INop),
      .issue_valid(issue_valid), .fifo_count(fifo_count),
      .stall_cycles(stall_cycles));

   issue_decode #(.DEPTH(DEPTH), .HAZ_DEPTH(SHAZ)) u_sat (
      .clk(clk), .rst_n(s_rst_n), .in_instr(s_in_instr),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .RR1(s_RR1),
      .RR2(s_RR2), .WR(s_WR), .INop(s_INop), .issue_valid(s_issue_valid),
      .fifo_count(s_fifo_count), .stall_cycles(s_stall));

   typedef struct {
      int         acc;
      int         iss;
      int         cum;
      logic [2:0] op;
      logic [4:0] wr, rr1, rr2;
   } item_t;

   item_t hist[$];
   item_t sb[$];
   int    last_iss = -1000;
   int    cum_stall = 0;
   int    n_chk = 0;
   int    n_pass = 0;
   int    cyc = 0;
   bit    mon_en = 0;
   bit    saw_full = 0;
   int    s_n = 0;
   int    s_last = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)",
                    name, act, exp, cyc);
   endtask

   task automatic fail(input string name);
      n_chk++;
      $display("FAIL %s (edge %0d)", name, cyc);
   endtask

   function automatic logic [31:0] mk(input logic [2:0] op,
         input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2);
      return {op, wr, r1, r2, 14'h2A5};
   endfunction

   // Words sitting in the FIFO just before edge k.
   function automatic int occ_before(input int k);
      int n = 0;
      foreach (hist[j]) if (hist[j].acc < k && hist[j].iss >= k) n++;
      return n;
   endfunction

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   function automatic bit reads(input logic [4:0] src, input logic [4:0] d);
      return (src != 0) && (src == d);
   endfunction

   task automatic model_reset();
      hist.delete();
      sb.delete();
      last_iss  = -1000;
      cum_stall = 0;
   endtask

   task automatic send(input logic [31:0] w);
      int    k, base, t;
      bit    rdy;
      item_t it;
      in_instr = w;
      in_valid = 1'b1;
      for (int tries = 0; tries < 200; tries++) begin
         k   = cyc + 1;
         rdy = occ_before(k) < DEPTH;
         chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
         @(posedge clk);
         #1;
         if (rdy) begin
            it.op  = w[31:29];
            it.wr  = w[28:24];
            it.rr1 = w[23:19];
            it.rr2 = w[18:14];
            it.acc = k;
            base = (last_iss + 1 > k + 1) ? last_iss + 1 : k + 1;
            t    = base;
            // A producer blocks its readers until HAZ edges after its issue.
            foreach (hist[j]) begin
               if (reads(it.rr1, hist[j].wr) || reads(it.rr2, hist[j].wr))
                  if (hist[j].iss + HAZ + 1 > t) t = hist[j].iss + HAZ + 1;
            end
            cum_stall += t - base;
            last_iss   = t;
            it.iss     = t;
            it.cum     = cum_stall;
            hist.push_back(it);
            sb.push_back(it);
            in_valid = 1'b0;
            return;
         end
      end
      fail("send_timeout");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "send bound expired");
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      item_t it;
      if (rst_n && mon_en) begin
         chk("fifo_count", {29'd0, fifo_count}, occ_before(cyc + 1));
         if (fifo_count == 3'd4) saw_full = 1;
         if (issue_valid) begin
            if (sb.size() == 0) begin
               fail("unexpected_issue");
            end else begin
               it = sb.pop_front();
               chk("issue_edge", cyc, it.iss);
               chk("issue_fields", {14'd0, INop, WR, RR1, RR2},
                   {14'd0, it.op, it.wr, it.rr1, it.rr2});
               chk("stall_at_issue", {16'd0, stall_cycles}, sat16(it.cum));
            end
         end else begin
            chk("bubble_fields", {14'd0, INop, WR, RR1, RR2}, 32'd0);
            if (sb.size() > 0 && sb[0].iss <= cyc) begin
               fail("missed_issue");
               void'(sb.pop_front());
            end
         end
      end
   end

   always @(negedge clk) begin
      int e;
      if (s_rst_n && s_issue_valid) begin
         s_n++;
         e = sat16(SHAZ * (s_n - 1));
         chk("sat_stall", {16'd0, s_stall}, e);
         chk("sat_fields", {14'd0, s_INop, s_WR, s_RR1, s_RR2},
             {14'd0, 3'd2, 5'd1, 5'd1, 5'd1});
         if (s_n > 1) chk("sat_spacing", cyc - s_last, SHAZ + 1);
         s_last = cyc;
      end
   end

   initial begin
      rst_n      = 1'b0;
      s_rst_n    = 1'b0;
      in_valid   = 1'b0;
      in_instr   = '0;
      s_in_valid = 1'b1;
      s_in_instr = mk(3'd2, 5'd1, 5'd1, 5'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_outs", {issue_valid, INop, WR, RR1, RR2, fifo_count,
          stall_cycles}, 32'd0);
      rst_n   = 1'b1;
      s_rst_n = 1'b1;
      mon_en  = 1;
      idle(2);

      // Mid-stream reset with B, C, D still queued behind a hazard.
      send(mk(3'd1, 5'd5, 5'd10, 5'd11));
      send(mk(3'd2, 5'd6, 5'd5, 5'd11));
      send(mk(3'd3, 5'd7, 5'd10, 5'd11));
      send(mk(3'd4, 5'd8, 5'd10, 5'd11));
      chk("pre_rst_count", {29'd0, fifo_count}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("midrst_outs", {issue_valid, INop, WR, RR1, RR2, fifo_count,
          stall_cycles}, 32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_count", {29'd0, fifo_count}, 32'd0);
      idle(4);

      send(mk(3'd1, 5'd1, 5'd10, 5'd11));
      send(mk(3'd2, 5'd2, 5'd10, 5'd11));
      send(mk(3'd3, 5'd3, 5'd10, 5'd11));
      idle(4);
      chk("indep_stall", {16'd0, stall_cycles}, 32'd0);

      send(mk(3'd1, 5'd5, 5'd10, 5'd11));
      send(mk(3'd2, 5'd9, 5'd5, 5'd11));
      idle(6);
      chk("d1_rr1_stall", {16'd0, stall_cycles}, 32'd2);
      send(mk(3'd1, 5'd5, 5'd10, 5'd11));
      send(mk(3'd2, 5'd9, 5'd12, 5'd5));
      idle(6);
      chk("d1_rr2_stall", {16'd0, stall_cycles}, 32'd4);

      send(mk(3'd1, 5'd5, 5'd10, 5'd11));
      send(mk(3'd5, 5'd6, 5'd10, 5'd11));
      send(mk(3'd2, 5'd9, 5'd12, 5'd5));
      send(mk(3'd3, 5'd0, 5'd10, 5'd11));
      send(mk(3'd4, 5'd9, 5'd0, 5'd0));
      idle(6);
      chk("d2_r0_stall", {16'd0, stall_cycles}, 32'd5);

      saw_full = 0;
      send(mk(3'd1, 5'd7, 5'd10, 5'd11));
      send(mk(3'd2, 5'd8, 5'd7, 5'd11));
      send(mk(3'd3, 5'd3, 5'd8, 5'd11));
      send(mk(3'd4, 5'd4, 5'd10, 5'd11));
      send(mk(3'd5, 5'd5, 5'd10, 5'd11));
      send(mk(3'd6, 5'd6, 5'd10, 5'd11));
      idle(10);
      chk("full_reached", {31'd0, saw_full}, 32'd1);

      for (int i = 0; i < 400; i++) begin
         send(mk(3'($urandom_range(7)), 5'($urandom_range(7)),
                 5'($urandom_range(7)), 5'($urandom_range(7))));
         if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
      end
      idle(12);
      chk("drained", sb.size(), 32'd0);
      chk("final_stall", {16'd0, stall_cycles}, sat16(cum_stall));

      for (int g = 0; g < 80000 && s_n < SAT_N; g++) @(posedge clk);
      if (s_n < SAT_N) fail("sat_timeout");
      chk("sat_hold", {16'd0, s_stall}, 32'hFFFF);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
